goertzel_power_detect: RTL and testbench

- Downstream consumer of the fixed-bin Goertzel IIR stage. Takes each complex DFT result {Re, Im} from that stage's AXI4-Stream output.
- Computes the bin power Re²+Im² and averages it over NAVG consecutive windows.
- Emits the averaged power on AXI4-Stream with a threshold-detect flag for the processing system.

---
 rtl/goertzel_power_detect.sv | 153 +++++++++++++++
 tb/tb_goertzel_power_detect.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_power_detect.sv
// Goertzel bin power detector: squares {Re,Im}, averages NAVG windows,
// and presents the mean power with a strict threshold flag on AXI4-Stream.
module goertzel_power_detect #(
    parameter int OW   = 20,
    parameter int NAVG = 4,
    parameter int PW   = 2 * OW
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2*OW-1:0] s_axis_tdata,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic [PW-1:0]   i_threshold,
    output logic [PW-1:0]   m_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            o_detect
);

    localparam int LG = $clog2(NAVG);
    localparam int CW = (LG > 0) ? LG : 1;
    localparam int AW = PW + LG;

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_t;

    logic                 ce;

    logic signed [OW-1:0] re_q, re_d;
    logic signed [OW-1:0] im_q, im_d;
    logic                 v0_q, v0_d;

    logic [PW-1:0]        sq_re_q, sq_re_d;
    logic [PW-1:0]        sq_im_q, sq_im_d;
    logic                 v1_q, v1_d;

    logic [PW-1:0]        p_q, p_d;
    logic                 v2_q, v2_d;

    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    state_t               state_q, state_d;

    logic [PW-1:0]        out_q, out_d;
    logic                 mval_q, mval_d;
    logic                 det_q, det_d;

    logic [AW-1:0]        sum;
    logic [AW-1:0]        avg_full;
    logic [PW-1:0]        avg;
    logic                 last;

    // A held output that downstream refuses freezes the whole pipeline.
    assign ce = !(mval_q && !m_axis_tready) && !i_rst;

    assign s_axis_tready = ce;
    assign m_axis_tdata  = out_q;
    assign m_axis_tvalid = mval_q;
    assign o_detect      = det_q;

    assign sum      = acc_q + AW'(p_q);
    assign avg_full = sum >> LG;
    assign avg      = avg_full[PW-1:0];
    assign last     = (cnt_q == CW'(NAVG - 1));

    always_comb begin
        re_d    = re_q;
        im_d    = im_q;
        v0_d    = v0_q;
        sq_re_d = sq_re_q;
        sq_im_d = sq_im_q;
        v1_d    = v1_q;
        p_d     = p_q;
        v2_d    = v2_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        out_d   = out_q;
        mval_d  = mval_q;
        det_d   = det_q;

        if (ce) begin
            v0_d    = s_axis_tvalid;
            re_d    = s_axis_tdata[2*OW-1:OW];
            im_d    = s_axis_tdata[OW-1:0];

            v1_d    = v0_q;
            sq_re_d = PW'(re_q) * PW'(re_q);
            sq_im_d = PW'(im_q) * PW'(im_q);

            v2_d    = v1_q;
            p_d     = sq_re_q + sq_im_q;

            // ce high while holding means the output handshake completes now.
            if (state_q == ST_HOLD) begin
                state_d = ST_ACCUM;
                mval_d  = 1'b0;
                det_d   = 1'b0;
            end

            if (v2_q) begin
                if (last) begin
                    out_d   = avg;
                    det_d   = (avg > i_threshold);
                    mval_d  = 1'b1;
                    state_d = ST_HOLD;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    acc_d   = sum;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            re_q    <= '0;
            im_q    <= '0;
            v0_q    <= 1'b0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            v1_q    <= 1'b0;
            p_q     <= '0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_ACCUM;
            out_q   <= '0;
            mval_q  <= 1'b0;
            det_q   <= 1'b0;
        end else begin
            re_q    <= re_d;
            im_q    <= im_d;
            v0_q    <= v0_d;
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            v1_q    <= v1_d;
            p_q     <= p_d;
            v2_q    <= v2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            out_q   <= out_d;
            mval_q  <= mval_d;
            det_q   <= det_d;
        end
    end

endmodule

// File: tb/tb_goertzel_power_detect.sv
// Directed bench for goertzel_power_detect with OW=20, NAVG=4.
module tb_goertzel_power_detect;

    logic        i_clk;
    logic        i_rst;
    logic [39:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [39:0] i_threshold;
    logic [39:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        o_detect;

    int errors = 0;
    int checks = 0;

    logic [39:0] q_data[$];
    logic        q_det[$];

    goertzel_power_detect #(.OW(20), .NAVG(4)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .i_threshold   (i_threshold),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .o_detect      (o_detect)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (!i_rst && m_axis_tvalid && m_axis_tready) begin
            q_data.push_back(m_axis_tdata);
            q_det.push_back(o_detect);
        end
    end

    task automatic send(input logic signed [19:0] re,
                        input logic signed [19:0] im);
        int  n;
        logic took;
        n = 0;
        do begin
            @(negedge i_clk);
            s_axis_tdata  = {re, im};
            s_axis_tvalid = 1'b1;
            #1 took = s_axis_tready;
            @(posedge i_clk);
            n++;
        end while (!took && n < 300);
        if (!took) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_axis_tready stuck at 0");
        end
    endtask

    task automatic wait_outs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            s_axis_tvalid = 1'b0;
            if (q_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge i_clk);
    endtask

    task automatic test_reset;
        @(negedge i_clk);
        i_rst = 1'b1;
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_ready: got %b want 0", s_axis_tready);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_m_valid: got %b want 0", m_axis_tvalid);
        end
        checks++;
        if (m_axis_tdata !== 40'd0) begin
            errors++;
            $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata);
        end
        checks++;
        if (o_detect !== 1'b0) begin
            errors++;
            $display("FAIL reset_detect: got %b want 0", o_detect);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_basic_latency;
        bit ok;
        q_data.delete();
        q_det.delete();
        i_threshold = 40'd24;
        repeat (4) send(20'sd3, 20'sd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            s_axis_tvalid = 1'b0;
            checks++;
            if (m_axis_tvalid !== (k == 3)) begin
                errors++;
                $display("FAIL latency_k%0d: tvalid got %b want %b",
                         k, m_axis_tvalid, (k == 3));
            end
        end
        wait_outs(1, ok);
        checks++;
        if (!ok || q_data.size() != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d want 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 40'd25) begin
                errors++;
                $display("FAIL basic_tdata: got %0d want 25", q_data[0]);
            end
            checks++;
            if (q_det[0] !== 1'b1) begin
                errors++;
                $display("FAIL basic_detect: got %b want 1", q_det[0]);
            end
        end
    endtask

    task automatic test_threshold_strict;
        bit ok;
        q_data.delete();
        q_det.delete();
        i_threshold = 40'd25;
        repeat (4) send(20'sd3, 20'sd4);
        wait_outs(1, ok);
        checks++;
        if (!ok || q_data.size() != 1) begin
            errors++;
            $display("FAIL strict_count: got %0d want 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 40'd25) begin
                errors++;
                $display("FAIL strict_tdata: got %0d want 25", q_data[0]);
            end
            checks++;
            if (q_det[0] !== 1'b0) begin
                errors++;
                $display("FAIL strict_detect: got %b want 0", q_det[0]);
            end
        end
    endtask

    task automatic test_truncation;
        bit ok;
        q_data.delete();
        q_det.delete();
        i_threshold = 40'd99;
        send(20'sd0, 20'sd0);
        send(20'sd6, 20'sd8);
        send(20'sd10, 20'sd10);
        send(20'sd10, 20'sd1);
        wait_outs(1, ok);
        checks++;
        if (!ok || q_data.size() != 1) begin
            errors++;
            $display("FAIL trunc_count: got %0d want 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 40'd100) begin
                errors++;
                $display("FAIL trunc_tdata: got %0d want 100", q_data[0]);
            end
            checks++;
            if (q_det[0] !== 1'b1) begin
                errors++;
                $display("FAIL trunc_detect: got %b want 1", q_det[0]);
            end
        end
    endtask

    task automatic test_max_power;
        bit ok;
        q_data.delete();
        q_det.delete();
        i_threshold = 40'd549755813888;
        repeat (4) send(-20'sd524288, -20'sd524288);
        wait_outs(1, ok);
        checks++;
        if (!ok || q_data.size() != 1) begin
            errors++;
            $display("FAIL max_count: got %0d want 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 40'd549755813888) begin
                errors++;
                $display("FAIL max_tdata: got %0d want 549755813888",
                         q_data[0]);
            end
            checks++;
            if (q_det[0] !== 1'b0) begin
                errors++;
                $display("FAIL max_detect: got %b want 0", q_det[0]);
            end
        end
    endtask

    task automatic test_back_to_back_stall;
        bit ok;
        bit seen;
        q_data.delete();
        q_det.delete();
        i_threshold = 40'd50;
        m_axis_tready = 1'b0;
        fork
            begin
                repeat (4) send(20'sd3, 20'sd4);
                repeat (4) send(20'sd6, 20'sd8);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge i_clk);
                    #1;
                    if (m_axis_tvalid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("FAIL stall_first_out: tvalid never rose");
                end
                for (int i = 0; i < 10; i++) begin
                    checks++;
                    if (s_axis_tready !== 1'b0 || m_axis_tdata !== 40'd25
                        || m_axis_tvalid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold_%0d: ready=%b valid=%b tdata=%0d want 0 1 25",
                                 i, s_axis_tready, m_axis_tvalid, m_axis_tdata);
                    end
                    @(negedge i_clk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_outs(2, ok);
        checks++;
        if (!ok || q_data.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 40'd25 || q_det[0] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_first: got %0d/%b want 25/0",
                         q_data[0], q_det[0]);
            end
            checks++;
            if (q_data[1] !== 40'd100 || q_det[1] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_second: got %0d/%b want 100/1",
                         q_data[1], q_det[1]);
            end
        end
    endtask

    task automatic test_reset_mid_block;
        bit ok;
        q_data.delete();
        q_det.delete();
        i_threshold = 40'd0;
        send(20'sd3, 20'sd4);
        send(20'sd3, 20'sd4);
        @(negedge i_clk);
        s_axis_tvalid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0
            || m_axis_tdata !== 40'd0 || o_detect !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs: ready=%b valid=%b tdata=%0d det=%b want all 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, o_detect);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) send(20'sd3, 20'sd4);
        wait_outs(1, ok);
        checks++;
        if (!ok || q_data.size() != 1) begin
            errors++;
            $display("FAIL midrst_count: got %0d want 1", q_data.size());
        end else begin
            checks++;
            if (q_data[0] !== 40'd25) begin
                errors++;
                $display("FAIL midrst_tdata: got %0d want 25", q_data[0]);
            end
        end
    endtask

    initial begin
        i_rst         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        i_threshold   = '0;
        m_axis_tready = 1'b1;
        test_reset;
        test_basic_latency;
        test_threshold_strict;
        test_truncation;
        test_max_power;
        test_back_to_back_stall;
        test_reset_mid_block;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
